// File: rtl/dpwm_ramp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpwm_ctrl_pkg
// Description : Shared definitions for the DPWM sequencing controller.
//               Contains the FSM state encoding, the default data width and
//               the default ramp step and watchdog margin.
// Revision    : 1.0 - initial release
// ============================================================================
package dpwm_ctrl_pkg;

    // Default width of the duty, period and dead-time words
    localparam int unsigned c_default_width = 12;

    // Default duty increment per PWM period while ramping
    localparam logic [11:0] c_default_step = 12'd4;

    // Default watchdog slack, in hfclk cycles, beyond one period
    localparam logic [11:0] c_default_wd_margin = 12'd16;

    // State codes are visible on the state port, so they are fixed explicitly
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_ramp  = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_fault = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_RAMP  = c_st_ramp,
        ST_RUN   = c_st_run,
        ST_FAULT = c_st_fault
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dpwm_ramp_ctrl_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : pwm_edge_det
// Description : Two-flop registered rising-edge detector on the PWM feedback.
//               Produces a one-cycle period-boundary pulse.
// Ports       : clk    - clock, rising edge
//               rst    - asynchronous active-high reset
//               i_pwm  - PWM feedback from the DPWM
//               o_bnd  - one-cycle pulse after a registered rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_edge_det
    import dpwm_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    output logic o_bnd
);

    logic r_pwm_q1;
    logic r_pwm_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_q1 <= 1'b0;
            r_pwm_q2 <= 1'b0;
        end else begin
            r_pwm_q1 <= i_pwm;
            r_pwm_q2 <= r_pwm_q1;
        end
    end

    // Both operands are registered, so the pulse is glitch-free
    assign o_bnd = r_pwm_q1 & ~r_pwm_q2;

endmodule
`default_nettype wire

// File: rtl/dpwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dpwm_ramp_ctrl
// Description : Sequencing controller for the DPWM. Host configuration is
//               taken over valid/ready into shadow registers and committed at
//               PWM period boundaries; duty is soft-started by a per-period
//               ramp; a latched fault holds the DPWM in reset until cleared.
// Ports       : hfclk, reset            - clock / async active-high reset
//               enable, fault, fault_clr - run request, fault in, fault clear
//               cfg_valid/cfg_ready      - config handshake
//               cfg_d/fs/dt1/dt2         - requested duty, period, dead times
//               pwm                      - PWM feedback from the DPWM
//               d/fs/dt1/dt2, dpwm_rst   - registered DPWM drive
//               state                    - current state code
// Options     : DPWM_CTRL_WATCHDOG_EN - compiles in the stalled-PWM watchdog
// Revision    : 1.0 - initial release
// ============================================================================
module dpwm_ramp_ctrl
    import dpwm_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH     = c_default_width,
    parameter logic [WIDTH-1:0] STEP      = WIDTH'(c_default_step),
    parameter logic [WIDTH-1:0] WD_MARGIN = WIDTH'(c_default_wd_margin)
) (
    input  logic             hfclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fault,
    input  logic             fault_clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_d,
    input  logic [WIDTH-1:0] cfg_fs,
    input  logic [WIDTH-1:0] cfg_dt1,
    input  logic [WIDTH-1:0] cfg_dt2,
    input  logic             pwm,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] fs,
    output logic [WIDTH-1:0] dt1,
    output logic [WIDTH-1:0] dt2,
    output logic             dpwm_rst,
    output logic [1:0]       state
);

    // Duty target can never reach the period; a zero period forces zero duty
    function automatic logic [WIDTH-1:0] clamp_target(input logic [WIDTH-1:0] req_d,
                                                      input logic [WIDTH-1:0] req_fs);
        if (req_fs == '0)
            return '0;
        else if (req_d > (req_fs - WIDTH'(1)))
            return req_fs - WIDTH'(1);
        else
            return req_d;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_d, w_d_nxt;
    logic             r_dpwm_rst, w_dpwm_rst_nxt;
    logic             r_cfg_ready;
    logic [WIDTH-1:0] r_fs, r_dt1, r_dt2, r_tgt;
    logic [WIDTH-1:0] r_sh_fs, r_sh_dt1, r_sh_dt2, r_sh_tgt;

    logic             w_bnd;
    logic             w_accept;
    logic             w_commit;
    logic             w_run_like;
    logic             w_wd_to;
    logic [WIDTH:0]   w_d_plus;
    logic [WIDTH-1:0] w_tgt_eff;
    logic [WIDTH-1:0] w_step_d;

    pwm_edge_det u_edge_det (
        .clk   (hfclk),
        .rst   (reset),
        .i_pwm (pwm),
        .o_bnd (w_bnd)
    );

    assign w_run_like = (r_state == ST_RAMP) || (r_state == ST_RUN);
    assign w_accept   = cfg_valid & r_cfg_ready;

    // cfg_ready low means a shadow word is pending. While running it waits for
    // a boundary, and loses to any higher-priority transition so the shadow
    // survives an enable drop. An accept on a boundary cycle cannot commit
    // there because the shadow is not yet pending.
    assign w_commit = ~r_cfg_ready &
                      (w_run_like ? (w_bnd & ~fault & enable & ~w_wd_to) : 1'b1);

    // Ramp arithmetic at WIDTH+1 bits so d+STEP never wraps
    assign w_d_plus  = {1'b0, r_d} + {1'b0, STEP};
    assign w_tgt_eff = w_commit ? r_sh_tgt : r_tgt;
    assign w_step_d  = (w_d_plus > {1'b0, w_tgt_eff}) ? w_tgt_eff : w_d_plus[WIDTH-1:0];

`ifdef DPWM_CTRL_WATCHDOG_EN
    logic [WIDTH:0] r_wd_cnt;
    logic [WIDTH:0] w_wd_inc;
    logic [WIDTH:0] w_wd_lim;

    assign w_wd_inc = r_wd_cnt + (WIDTH+1)'(1);
    assign w_wd_lim = {1'b0, r_fs} + {1'b0, WD_MARGIN};
    // Fires on the edge where the count would reach the limit
    assign w_wd_to  = w_run_like & ~w_bnd & (w_wd_inc >= w_wd_lim);

    always_ff @(posedge hfclk or posedge reset) begin
        if (reset)
            r_wd_cnt <= '0;
        else if (!w_run_like || w_bnd ||
                 (w_state_nxt == ST_RAMP && r_state != ST_RAMP))
            r_wd_cnt <= '0;
        else
            r_wd_cnt <= w_wd_inc;
    end
`else
    logic w_unused_wd_margin;
    assign w_unused_wd_margin = ^WD_MARGIN;
    assign w_wd_to = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_d_nxt        = r_d;
        w_dpwm_rst_nxt = r_dpwm_rst;
        if (fault) begin
            w_state_nxt    = ST_FAULT;
            w_d_nxt        = '0;
            w_dpwm_rst_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_d_nxt        = '0;
                    w_dpwm_rst_nxt = 1'b1;
                    if (enable && r_fs != '0) begin
                        w_state_nxt    = ST_RAMP;
                        w_dpwm_rst_nxt = 1'b0;
                    end
                end
                ST_RAMP, ST_RUN: begin
                    if (w_wd_to || (w_commit && r_sh_fs == '0)) begin
                        w_state_nxt    = ST_FAULT;
                        w_d_nxt        = '0;
                        w_dpwm_rst_nxt = 1'b1;
                    end else if (!enable) begin
                        w_state_nxt    = ST_IDLE;
                        w_d_nxt        = '0;
                        w_dpwm_rst_nxt = 1'b1;
                    end else if (r_state == ST_RAMP) begin
                        w_dpwm_rst_nxt = 1'b0;
                        // Stepping against the new target also pulls d down
                        // when a commit lowers it below the current duty
                        if (w_bnd)
                            w_d_nxt = w_step_d;
                        else if (r_d == r_tgt)
                            w_state_nxt = ST_RUN;
                    end else begin
                        w_dpwm_rst_nxt = 1'b0;
                        if (w_commit) begin
                            if ({1'b0, r_sh_tgt} <= w_d_plus)
                                w_d_nxt = r_sh_tgt;
                            else
                                w_state_nxt = ST_RAMP;
                        end
                    end
                end
                ST_FAULT: begin
                    w_d_nxt        = '0;
                    w_dpwm_rst_nxt = 1'b1;
                    if (fault_clr)
                        w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_d_nxt        = '0;
                    w_dpwm_rst_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge hfclk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_d         <= '0;
            r_dpwm_rst  <= 1'b1;
            r_cfg_ready <= 1'b1;
            r_fs        <= '0;
            r_dt1       <= '0;
            r_dt2       <= '0;
            r_tgt       <= '0;
            r_sh_fs     <= '0;
            r_sh_dt1    <= '0;
            r_sh_dt2    <= '0;
            r_sh_tgt    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_d        <= w_d_nxt;
            r_dpwm_rst <= w_dpwm_rst_nxt;
            if (w_accept) begin
                r_sh_fs     <= cfg_fs;
                r_sh_dt1    <= cfg_dt1;
                r_sh_dt2    <= cfg_dt2;
                r_sh_tgt    <= clamp_target(cfg_d, cfg_fs);
                r_cfg_ready <= 1'b0;
            end else if (w_commit) begin
                r_fs        <= r_sh_fs;
                r_dt1       <= r_sh_dt1;
                r_dt2       <= r_sh_dt2;
                r_tgt       <= r_sh_tgt;
                r_cfg_ready <= 1'b1;
            end
        end
    end

    assign d         = r_d;
    assign fs        = r_fs;
    assign dt1       = r_dt1;
    assign dt2       = r_dt2;
    assign dpwm_rst  = r_dpwm_rst;
    assign cfg_ready = r_cfg_ready;
    assign state     = r_state;

endmodule
`default_nettype wire
